// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC round-robin output arbiter.
// Optional hold limiting is enabled in the arbiter with macro ARB_HOLD_LIMIT_EN.
package noc_arb_pkg;

  localparam int NUM_PORTS_DEF = 5;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  typedef logic [NUM_PORTS_DEF-1:0] port_vec_t;

  // Ceiling log2 for elaboration-time widths.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Rotating-priority picker: first set request at or after start (or strictly
// after it when excl is set), wrapping at N-1, returned one-hot.
module rr_pick_onehot
  import noc_arb_pkg::*;
#(
  parameter int N  = NUM_PORTS_DEF,
  parameter int IW = clog2(NUM_PORTS_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic          excl,
  output logic [N-1:0]  pick
);

  int first_s;
  int best_s;
  int dist_s;

  // Rank every requester by its rotated distance from the first eligible slot.
  always_comb begin
    first_s = (int'(start) + int'(excl)) % N;
    best_s  = N;
    dist_s  = 0;
    pick    = '0;
    for (int i = 0; i < N; i++) begin
      dist_s = (i + N - first_s) % N;
      if (req[i] && (dist_s < best_s)) begin
        best_s = dist_s;
      end else begin
        best_s = best_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      dist_s  = (i + N - first_s) % N;
      pick[i] = req[i] && (dist_s == best_s);
    end
  end

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter with sticky ownership and rts/dcts handshake.
// Define ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD grants to one owner.
module noc_rr_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int MAX_HOLD  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts
);

  localparam int IW = clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] owner_r;
  logic                 rts_r;
  logic [IW-1:0]        ptr_r;

  logic [NUM_PORTS-1:0] next_owner_s;
  logic [NUM_PORTS-1:0] owner_d_s;
  logic [NUM_PORTS-1:0] grant_s;
  logic [IW-1:0]        owner_idx_s;
  logic [IW-1:0]        next_idx_s;
  logic [IW-1:0]        start_s;
  logic                 stall_s;
  logic                 pulse_s;
  logic                 excl_s;

  // Handshake decode, scan origin and the owner value for the next edge.
  always_comb begin
    pulse_s   = rts_r & dcts;
    stall_s   = rts_r & ~dcts;
    grant_s   = owner_r & {NUM_PORTS{pulse_s}};
    if (owner_r == '0) begin
      start_s = ptr_r;
    end else begin
      start_s = owner_idx_s;
    end
    if (stall_s) begin
      owner_d_s = owner_r;
    end else begin
      owner_d_s = next_owner_s;
    end
  end

  // One-hot to index for the current and the upcoming owner.
  always_comb begin
    owner_idx_s = '0;
    next_idx_s  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner_r[i]) begin
        owner_idx_s = IW'(i);
      end else begin
        owner_idx_s = owner_idx_s;
      end
      if (owner_d_s[i]) begin
        next_idx_s = IW'(i);
      end else begin
        next_idx_s = next_idx_s;
      end
    end
  end

  rr_pick_onehot #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .start (start_s),
    .excl  (excl_s),
    .pick  (next_owner_s)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt_r;
  logic          others_s;

  // Skip past the owner once it has used its share and someone else waits.
  always_comb begin
    others_s = |(req & ~owner_r);
    excl_s   = pulse_s && (owner_r != '0) && others_s &&
               (hold_cnt_r == HW'(MAX_HOLD - 1));
  end

  // Grant count for the current owner; saturates so a lone owner never wraps
  // the counter and the limit still applies once a competitor shows up.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_r <= '0;
    end else if (owner_d_s != owner_r) begin
      hold_cnt_r <= '0;
    end else if (pulse_s && (owner_r != '0) && (hold_cnt_r < HW'(MAX_HOLD - 1))) begin
      hold_cnt_r <= hold_cnt_r + HW'(1);
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end
`else
  assign excl_s = 1'b0;
`endif

  // Owner, request-to-send and last-owner pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= '0;
      rts_r   <= 1'b0;
      ptr_r   <= '0;
    end else begin
      owner_r <= owner_d_s;
      rts_r   <= (owner_r != '0) && !pulse_s;
      if (owner_d_s != '0) begin
        ptr_r <= next_idx_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  assign grant    = grant_s;
  assign xbar_sel = owner_r;
  assign rts      = rts_r;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Self-checking bench for noc_rr_arbiter: integer-level reference model plus
// directed vectors with hand-computed expectations.
module tb_noc_rr_arbiter;

  localparam int NP   = 5;
  localparam int MAXH = 2;

  logic          clk;
  logic          rst;
  logic [NP-1:0] req;
  logic          dcts;
  logic [NP-1:0] grant;
  logic [NP-1:0] xbar_sel;
  logic          rts;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  noc_rr_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .dcts     (dcts),
    .grant    (grant),
    .xbar_sel (xbar_sel),
    .rts      (rts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner as a port number (-1 = idle).
  int m_owner = -1;
  bit m_rts   = 1'b0;
  int m_ptr   = 0;
  int m_hold  = 0;
  int nx_owner, nx_ptr, nx_hold, found, st, idx;
  bit nx_rts, gp, ex;

  function automatic bit bit_at(input logic [NP-1:0] v, input int i);
    logic [NP-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [NP-1:0] vec(input int o);
    logic [NP-1:0] one;
    one = 5'd1;
    if (o < 0) return 5'd0;
    return one << o;
  endfunction

  always_comb begin
    gp = (m_owner >= 0) && m_rts && dcts;
    st = (m_owner < 0) ? m_ptr : m_owner;
    ex = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    if (gp && (m_hold == MAXH - 1) && ((req & ~vec(m_owner)) != 5'd0)) ex = 1'b1;
`endif
    found = -1;
    idx = 0;
    for (int k = 0; k < NP; k++) begin
      idx = (st + int'(ex) + k) % NP;
      if (found < 0 && bit_at(req, idx)) found = idx;
    end
    nx_owner = (m_rts && !dcts) ? m_owner : found;
    nx_ptr   = (nx_owner >= 0) ? nx_owner : m_ptr;
    nx_rts   = (m_owner >= 0) && !(m_rts && dcts);
    if (nx_owner != m_owner) nx_hold = 0;
    else if (gp && m_hold < MAXH - 1) nx_hold = m_hold + 1;
    else nx_hold = m_hold;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1;
      m_rts   <= 1'b0;
      m_ptr   <= 0;
      m_hold  <= 0;
    end else begin
      m_owner <= nx_owner;
      m_rts   <= nx_rts;
      m_ptr   <= nx_ptr;
      m_hold  <= nx_hold;
    end
  end

  task automatic check(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_grant", grant, (m_owner >= 0 && m_rts && dcts) ? vec(m_owner) : 5'd0);
      check("model_xbar", xbar_sel, vec(m_owner));
      check("model_rts", {4'd0, rts}, {4'd0, m_rts});
    end
  end

  task automatic step(input logic [NP-1:0] r, input logic d, input logic rs);
    @(posedge clk);
    #1;
    req  = r;
    dcts = d;
    rst  = rs;
    @(negedge clk);
  endtask

  logic [NP-1:0] stall_req [10];
  logic [NP-1:0] exp37 [6];
  logic [NP-1:0] gq [$];

  initial begin
    stall_req = '{5'b00001, 5'b10000, 5'b00110, 5'b00000, 5'b11111,
                  5'b00100, 5'b10001, 5'b00010, 5'b01111, 5'b00000};
`ifdef ARB_HOLD_LIMIT_EN
    exp37 = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00001, 5'b00001};
`else
    exp37 = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
`endif
    rst = 1'b1; req = 5'd0; dcts = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Basic latency from reset
    step(5'b00001, 1'b1, 1'b0);
    check("rst_xbar", xbar_sel, 5'b00000);
    check("rst_rts", {4'd0, rts}, 5'd0);
    check("rst_grant", grant, 5'b00000);
    step(5'b00001, 1'b1, 1'b0);
    check("c1_xbar", xbar_sel, 5'b00001);
    check("c1_rts", {4'd0, rts}, 5'd0);
    step(5'b00001, 1'b1, 1'b0);
    check("c2_rts", {4'd0, rts}, 5'd1);
    check("c2_grant", grant, 5'b00001);
    step(5'b00001, 1'b1, 1'b0);
    check("c3_rts", {4'd0, rts}, 5'd0);
    check("c3_grant", grant, 5'b00000);
    step(5'b00001, 1'b1, 1'b0);
    check("c4_grant", grant, 5'b00001);

    // Owner hand-off as requesters drop out, then idle scan from ptr
    step(5'b00110, 1'b1, 1'b0);
    check("c5_xbar", xbar_sel, 5'b00001);
    step(5'b00110, 1'b1, 1'b0);
    check("c6_xbar", xbar_sel, 5'b00010);
    check("c6_grant", grant, 5'b00010);
    step(5'b00100, 1'b1, 1'b0);
    check("c7_xbar", xbar_sel, 5'b00010);
    step(5'b00100, 1'b1, 1'b0);
    check("c8_xbar", xbar_sel, 5'b00100);
    check("c8_grant", grant, 5'b00100);
    step(5'b00000, 1'b1, 1'b0);
    check("c9_xbar", xbar_sel, 5'b00100);
    step(5'b01001, 1'b1, 1'b0);
    check("c10_xbar", xbar_sel, 5'b00000);
    check("c10_grant", grant, 5'b00000);
    step(5'b01001, 1'b0, 1'b0);
    check("ptr_scan_xbar", xbar_sel, 5'b01000);

    // Downstream stall with changing requests
    for (int i = 0; i < 10; i++) begin
      step(stall_req[i], 1'b0, 1'b0);
      check("stall_xbar", xbar_sel, 5'b01000);
      check("stall_rts", {4'd0, rts}, 5'd1);
      check("stall_grant", grant, 5'b00000);
    end
    step(5'b01000, 1'b1, 1'b0);
    check("unstall_grant", grant, 5'b01000);
    step(5'b01000, 1'b0, 1'b0);
    check("post_grant", grant, 5'b00000);
    check("post_rts", {4'd0, rts}, 5'd0);

    // Reset mid-transfer, then idle scan restarts at port 0
    step(5'b01000, 1'b0, 1'b1);
    check("pre_rst_xbar", xbar_sel, 5'b01000);
    check("pre_rst_rts", {4'd0, rts}, 5'd1);
    step(5'b10010, 1'b1, 1'b0);
    check("mid_rst_xbar", xbar_sel, 5'b00000);
    check("mid_rst_rts", {4'd0, rts}, 5'd0);
    check("mid_rst_grant", grant, 5'b00000);
    step(5'b10010, 1'b1, 1'b0);
    check("rst_ptr_xbar", xbar_sel, 5'b00010);

    // Two constant requesters: grant sequence
    step(5'b00000, 1'b1, 1'b1);
    step(5'b00011, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(5'b00011, 1'b1, 1'b0);
      if (grant != 5'd0) gq.push_back(grant);
    end
    check("hold_pulses", 5'(gq.size()), 5'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++) check("hold_seq", gq[i], exp37[i]);

    // Wrap from the top port back to port 0
    step(5'b00000, 1'b1, 1'b1);
    step(5'b10000, 1'b1, 1'b0);
    step(5'b10000, 1'b1, 1'b0);
    check("wrap_own4", xbar_sel, 5'b10000);
    step(5'b00011, 1'b1, 1'b0);
    check("wrap_grant4", grant, 5'b10000);
    step(5'b00011, 1'b1, 1'b0);
    check("wrap_xbar0", xbar_sel, 5'b00001);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 120; i++) begin
      step(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/noc_rr_arbiter.md
NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 5, is the number of requesting input ports and SHALL be 2..16.
REQ-002 Parameter MAX_HOLD, default 8, is the number of consecutive grant pulses one owner may take while others wait, and SHALL be >=1.
REQ-003 Port clk, input, 1, is the clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-005 Port req, input, NUM_PORTS, carries per-port requests; bit i is port i.
REQ-006 Port dcts, input, 1, is the downstream clear-to-send.
REQ-007 Port grant, output, NUM_PORTS, is the one-hot grant pulse to the owning port.
REQ-008 Port xbar_sel, output, NUM_PORTS, is the one-hot crossbar select; it is 0 when idle.
REQ-009 Port rts, output, 1, is the registered request-to-send to downstream.

Function
REQ-010 The block SHALL hold registered state: owner (one-hot, NUM_PORTS bits, 0 = IDLE), rts_q, ptr (index of the last owner) and, with the macro, hold_cnt.
REQ-011 States SHALL be IDLE (owner==0) and SERVE(i) (owner==1<<i); no other encoding is legal.
REQ-012 Owner update: if rts_q && !dcts, owner SHALL hold; otherwise owner <= next_owner.
REQ-013 next_owner SHALL be the first set req bit scanning upward from a start index with wrap-around, or 0 if req==0.
REQ-014 In IDLE, the start index SHALL be ptr (inclusive); in SERVE(i), it SHALL be i (inclusive, sticky owner).
REQ-015 ptr SHALL load the index of owner whenever owner becomes non-zero.
REQ-016 rts_q next value: 0 if owner==0; else 0 if rts_q && dcts; else 1.
REQ-017 This gives one transfer per two cycles per owner.
REQ-018 grant[i] SHALL equal owner[i] & rts_q & dcts, combinational, and is at most one-hot.
REQ-019 xbar_sel SHALL equal owner.
REQ-020 Latency: req asserted in IDLE at cycle 0 gives owner at cycle 1, rts at cycle 2, and grant in cycle 2 if dcts=1.
REQ-021 If the owner drops req while rts_q && !dcts, ownership SHALL persist until dcts is seen.
REQ-022 Simultaneous requests SHALL be resolved solely by REQ-013/014.
REQ-023 A port index at NUM_PORTS-1 SHALL wrap to 0.

Reset
REQ-024 When rst=1 at an edge: owner=0, rts_q=0, ptr=0, hold_cnt=0.
REQ-025 Consequently grant=0, xbar_sel=0 and rts=0 from the next cycle, including when reset is asserted mid-transfer.
REQ-026 Reset SHALL take priority over all updates.

Configuration
REQ-027 Macro ARB_HOLD_LIMIT_EN, when defined, SHALL add a hold_cnt counter of width clog2(MAX_HOLD+1).
REQ-028 hold_cnt increments on each grant pulse and clears on any owner change.
REQ-029 When hold_cnt==MAX_HOLD-1 at a grant pulse and any other req bit is set, the SERVE start index SHALL become owner+1 (exclusive of owner), forcing rotation.
REQ-030 Without the macro, no counter SHALL exist and ownership is retained indefinitely while owner req stays high.

Structure
REQ-031 Package noc_arb_pkg SHALL hold the default NUM_PORTS and port index constants PORT_N=0, PORT_E=1, PORT_W=2, PORT_S=3, PORT_L=4.
REQ-032 Package noc_arb_pkg SHALL also hold a port-vector typedef and the clog2 helper.
REQ-033 Sub-module rr_pick_onehot (combinational rotating-priority picker: req, start index, exclusive flag -> one-hot) SHALL implement REQ-013.

Verification
REQ-034 Reset, then req=5'b00001, dcts=1: owner=00001 at cycle 1; rts=1 and grant=00001 at cycle 2; rts=0 at cycle 3; grant again at cycle 4.
REQ-035 In SERVE(0) with req=5'b00110 after port 0 drops: next owner=00010, then 00100 after port 1 drops; ptr tracks each.
REQ-036 rts=1, dcts=0 for 10 cycles while req changes: owner and rts stable, grant=0; dcts=1: one grant pulse.
REQ-037 With ARB_HOLD_LIMIT_EN and MAX_HOLD=2, req=5'b00011 constant: grants alternate port0, port0, port1, port1, ...; without the macro, port0 holds forever.
REQ-038 rst pulsed while owner=01000 and rts=1: next cycle owner=0, rts=0, grant=0; after release, IDLE scan restarts at index 0.
